// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier with hex display.
//   state_t   : multiplier FSM state encoding
//   GLYPH     : active-low seven-segment patterns for hex digits 0..F,
//               bit 0 = segment a ... bit 6 = segment g
//   nib()     : returns hex digit i of a vector of up to 64 bits
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // 0 1 2 3 4 5 6 7 8 9 A b C d E F
  localparam logic [6:0] GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] nib(input logic [63:0] v, input int unsigned i);
    return v[i*4 +: 4];
  endfunction

endpackage

// File: rtl/seq_mult_param_disp_hex_scan.sv
// Time-multiplexed hex display scanner.
//   clk  : system clock
//   clr  : asynchronous active-low reset
//   vbus : NDIG hex digits, digit 0 in bits [3:0]
//   an   : digit enables, active-low, exactly one low once running
//   ca   : segments of the selected digit, active-low
module hex_scan
  import seq_mult_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SCAN_BITS = 17
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NDIG*4-1:0] vbus,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        ca
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [SCAN_BITS-1:0] pre;
  logic [IW-1:0]        idx;
  logic                 on;
  logic [63:0]          vext;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre <= '0;
      idx <= '0;
      on  <= 1'b0;
    end else begin
      on  <= 1'b1;
      pre <= pre + 1'b1;
      if (pre == '1)
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
    end
  end

  // 'on' keeps both outputs blank while in reset; the digit is driven
  // from the first cycle after release.
  always_comb begin
    int unsigned sel;
    sel  = 32'(idx);
    vext = 64'(vbus);
    an   = '1;
    ca   = '1;
    if (on) begin
      an = ~(NDIG'(1) << idx);
      ca = GLYPH[nib(vext, sel)];
    end
  end

endmodule

// File: rtl/seq_mult_param_disp.sv
// Shift-add sequential multiplier (signed or unsigned per operation) with
// a scanned hex display of a, b and the held product.
//   clk  : system clock          clr  : async active-low reset
//   go   : start (IDLE only)     sgn  : 1 = two's complement operation
//   a, b : operands (W bits)     busy : operation in progress
//   done : one-cycle pulse when p updates
//   p    : held 2W-bit product
//   an   : digit enables (active-low), an[NDIG-1] leftmost
//   ca   : segments (active-low), ca[0] = a ... ca[6] = g
module seq_mult_param_disp
  import seq_mult_pkg::*;
#(
  parameter int W         = 4,
  parameter int SCAN_BITS = 17
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             go,
  input  logic             sgn,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   p,
  output logic [W-1:0]     an,
  output logic [6:0]       ca
);

  localparam int NDIG = W;
  localparam int CW   = $clog2(W + 1);

  state_t           state;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is correct as unsigned.
  always_comb begin
    abs_a = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    abs_b = (sgn && b[W-1]) ? (~b + W'(1)) : b;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (go) begin
            mcand  <= {{W{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= sgn & (a[W-1] ^ b[W-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1))
            state <= ST_FIX;
        end
        ST_FIX: begin
          p     <= neg ? (~acc + (2*W)'(1)) : acc;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hex_scan #(
    .NDIG      (NDIG),
    .SCAN_BITS (SCAN_BITS)
  ) u_scan (
    .clk  (clk),
    .clr  (clr),
    .vbus ({a, b, p}),
    .an   (an),
    .ca   (ca)
  );

endmodule

// File: tb/tb_seq_mult_param_disp.sv
module tb_seq_mult_param_disp;

  logic       clk = 1'b0;
  logic       clr;
  logic       go;
  logic       sgn;
  logic [3:0] a;
  logic [3:0] b;

  logic       busy1, done1;
  logic [7:0] p1;
  logic [3:0] an1;
  logic [6:0] ca1;

  logic       busy2, done2;
  logic [7:0] p2;
  logic [3:0] an2;
  logic [6:0] ca2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_mult_param_disp #(.W(4), .SCAN_BITS(17)) u_dut (
    .clk(clk), .clr(clr), .go(go), .sgn(sgn), .a(a), .b(b),
    .busy(busy1), .done(done1), .p(p1), .an(an1), .ca(ca1)
  );

  seq_mult_param_disp #(.W(4), .SCAN_BITS(2)) u_fast (
    .clk(clk), .clr(clr), .go(go), .sgn(sgn), .a(a), .b(b),
    .busy(busy2), .done(done2), .p(p2), .an(an2), .ca(ca2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with go pulsed for a single cycle.
  task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vs, input logic [7:0] exp_p);
    int busy_cnt, done_at, done_cnt;
    busy_cnt = 0; done_at = 0; done_cnt = 0;
    a = va; b = vb; sgn = vs; go = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) go = 1'b0;
      if (busy1) busy_cnt++;
      if (done1) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    check({tag, "_busy"}, 32'(busy_cnt), 32'd5);
    check({tag, "_done_at"}, 32'(done_at), 32'd6);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_p"}, 32'(p1), 32'(exp_p));
  endtask

  initial begin
    int d1, d2, dc;
    logic [3:0] prev_an;
    logic found;
    logic [3:0] exp_an [0:3];
    logic [6:0] exp_ca [0:3];
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_ca = '{7'b0001000, 7'b1111001, 7'b0100100, 7'b0100001};

    clr = 1'b0; go = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_p", 32'(p1), 32'd0);
    check("rst_an", 32'(an1), 32'hF);
    check("rst_ca", 32'(ca1), 32'h7F);
    #5 clr = 1'b1;
    tick();
    check("first_digit_an", 32'(an1), 32'hE);

    run_op("u13x11", 4'd13, 4'd11, 1'b0, 8'h8F);
    run_op("sm3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
    run_op("sm8xm8", 4'h8, 4'h8, 1'b1, 8'h40);

    // go held high: back-to-back operations, a changed during CALC
    a = 4'd2; b = 4'd3; sgn = 1'b0; go = 1'b1;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 2) a = 4'd7;
      if (i == 8) go = 1'b0;
      if (done1) begin
        if (d1 == 0) d1 = i;
        else if (d2 == 0) d2 = i;
      end
      if (i == 6) check("hold_p1", 32'(p1), 32'h06);
      if (i == 12) check("hold_p_kept", 32'(p1), 32'h06);
    end
    check("hold_done1", 32'(d1), 32'd6);
    check("hold_done2", 32'(d2), 32'd13);
    check("hold_p2", 32'(p1), 32'h15);

    // go re-pulsed during CALC is ignored
    a = 4'd3; b = 4'd5; go = 1'b1; dc = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) go = 1'b0;
      if (i == 3) begin go = 1'b1; a = 4'd1; b = 4'd1; end
      if (i == 4) go = 1'b0;
      if (i == 5) check("ign_p_before", 32'(p1), 32'h15);
      if (done1) dc++;
    end
    check("ign_done_cnt", 32'(dc), 32'd1);
    check("ign_p", 32'(p1), 32'h0F);

    // asynchronous reset mid-CALC
    a = 4'hF; b = 4'hF; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    #3 clr = 1'b0;
    #1;
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_done", 32'(done1), 32'd0);
    check("arst_p", 32'(p1), 32'd0);
    check("arst_an", 32'(an1), 32'hF);
    #2 clr = 1'b1;
    dc = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done1 || busy1) dc++;
    end
    check("arst_no_done", 32'(dc), 32'd0);

    // fast-scan instance: digits of a=D, b=2, p=1A
    run_op("u13x2", 4'hD, 4'h2, 1'b0, 8'h1A);
    check("fast_p", 32'(p2), 32'h1A);
    found = 1'b0;
    prev_an = an2;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (an2 == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
      prev_an = an2;
    end
    check("scan_sync", 32'(found), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("scan_an%0d", k), 32'(an2), 32'(exp_an[k]));
      check($sformatf("scan_ca%0d", k), 32'(ca2), 32'(exp_ca[k]));
      repeat (3) tick();
      check($sformatf("scan_hold%0d", k), 32'(an2), 32'(exp_an[k]));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
